// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and byte-assembly helper for the loadable instruction memory
package instr_mem_pkg;

  // Load controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

  // MOV R0,R0 - returned whenever the array must not be fetched from
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;

  // Assemble four consecutive bytes (b0 at the lowest address) into a fetch word
  function automatic logic [31:0] assemble_word(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic       big_endian
  );
    return big_endian ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/instr_load_ctrl.sv
// rtl/instr_load_ctrl.sv - program-load FSM: clears the array word by word, then streams bytes in
module instr_load_ctrl
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int LEN_W       = $clog2(DEPTH_BYTES) + 1,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_start,
  input  logic [LEN_W-1:0] ld_len,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  output logic             ld_ready,
  output logic             busy,
  output logic             ld_done,
  output logic             wr_en,
  output logic             wr_clear,
  output logic [AW-1:0]    wr_addr,
  output logic [7:0]       wr_data
);

  localparam int WW = AW - 2;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_BYTES);
  localparam logic [WW-1:0]    LAST_WORD = '1;

  ld_state_t        state;
  logic [LEN_W-1:0] len;
  logic [WW-1:0]    w;
  logic [LEN_W-1:0] b;

  // FSM, counters and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      len      <= '0;
      w        <= '0;
      b        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ld_done <= 1'b0;
          if (ld_start) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
            len   <= (ld_len > DEPTH_LEN) ? DEPTH_LEN : ld_len;
            w     <= '0;
            b     <= '0;
          end
        end
        ST_CLEAR: begin
          w <= w + WW'(1);
          if (w == LAST_WORD) begin
            if (len == '0) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              ld_done <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              ld_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            b <= b + LEN_W'(1);
            if (b == len - LEN_W'(1)) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          ld_done <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write port: whole-word zero during CLEAR, single accepted byte during LOAD
  assign wr_clear = (state == ST_CLEAR);
  assign wr_en    = wr_clear || ((state == ST_LOAD) && ld_valid);
  assign wr_addr  = wr_clear ? {w, 2'b00} : b[AW-1:0];
  assign wr_data  = wr_clear ? 8'h00 : ld_byte;

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - byte-addressed instruction memory with combinational fetch and runtime load port
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int BIG_ENDIAN  = 0,
  parameter int LEN_W       = $clog2(DEPTH_BYTES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      A,
  output logic [31:0]      RD,
  output logic             align_err,
  output logic             range_err,
  input  logic             ld_start,
  input  logic [LEN_W-1:0] ld_len,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  output logic             ld_ready,
  output logic             busy,
  output logic             ld_done
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic          wr_en;
  logic          wr_clear;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] a0, a1, a2, a3;

  instr_load_ctrl #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .LEN_W      (LEN_W),
    .AW         (AW)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .ld_start(ld_start),
    .ld_len  (ld_len),
    .ld_valid(ld_valid),
    .ld_byte (ld_byte),
    .ld_ready(ld_ready),
    .busy    (busy),
    .ld_done (ld_done),
    .wr_en   (wr_en),
    .wr_clear(wr_clear),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Array write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_clear) begin
        mem[{wr_addr[AW-1:2], 2'd0}] <= 8'h00;
        mem[{wr_addr[AW-1:2], 2'd1}] <= 8'h00;
        mem[{wr_addr[AW-1:2], 2'd2}] <= 8'h00;
        mem[{wr_addr[AW-1:2], 2'd3}] <= 8'h00;
      end else begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Error flags: A+3 at 33 bits so addresses near 2^32 never wrap into range
  assign align_err = (A[1:0] != 2'b00);
  assign range_err = (({1'b0, A} + 33'd3) >= 33'(DEPTH_BYTES));

  // Byte indices wrap harmlessly when out of range because RD is forced to NOP then
  assign a0 = A[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  // Fetch mux: NOP while loading or out of range, otherwise assembled bytes
  always_comb begin
    RD = NOP_WORD;
    if (!busy && !range_err) begin
      RD = assemble_word(mem[a0], mem[a1], mem[a2], mem[a3], BIG_ENDIAN != 0);
    end
  end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, byte-addressed instruction memory for the single-cycle ARM core, with a runtime program-load port replacing hard-coded initial contents. Fetch is combinational so the single-cycle datapath is unchanged. Width depth and byte order are parameters. A sequential load controller clears the array, accepts a byte stream, and signals completion. While a load is in progress, fetch returns NOP so the core idles safely.

## Interface
- DEPTH_BYTES, 256, array size in bytes; power of two, ≥ 8
- BIG_ENDIAN, 0, fetch byte order: 0 = {m[A+3],m[A+2],m[A+1],m[A]}; 1 = {m[A],m[A+1],m[A+2],m[A+3]}
- LEN_W, $clog2(DEPTH_BYTES)+1, width of ld_len

- clk  in  1  rising-edge clock (the only clock)
- reset  in  1  synchronous, active-high
- A  in  32  fetch byte address
- RD  out  32  fetch data (combinational)
- align_err  out  1  A[1:0] ≠ 0 (combinational)
- range_err  out  1  A + 3 ≥ DEPTH_BYTES (combinational)
- ld_start  in  1  request a new program load (sampled in IDLE only)
- ld_len  in  LEN_W  byte count, sampled with ld_start
- ld_valid  in  1  ld_byte is valid
- ld_byte  in  8  program byte; bytes arrive in ascending address order from 0
- ld_ready  out  1  block accepts a byte this cycle
- busy  out  1  CLEAR or LOAD in progress
- ld_done  out  1  one-cycle pulse at load completion

## Operation
- FSM states: IDLE, CLEAR, LOAD, DONE.
  - IDLE → CLEAR on ld_start. Latch len = min(ld_len, DEPTH_BYTES). Reset the word counter and byte counter to 0.
  - CLEAR writes 32'h0 to word counter w, one word per cycle. w increments each cycle. → LOAD after word DEPTH_BYTES/4−1 is written. If len = 0, → DONE instead.
  - LOAD: ld_ready = 1. On ld_valid && ld_ready, m[b] ← ld_byte and b increments. After byte len−1 is accepted → DONE.
  - DONE: ld_done = 1 for exactly one cycle, then → IDLE.
- ld_start in any state other than IDLE is ignored.
- ld_valid outside LOAD is ignored, and no write occurs.
- Fetch output:
  - When busy = 1, RD = NOP_WORD (32'hE1A00000, MOV R0,R0).
  - When range_err = 1, RD = NOP_WORD.
  - Otherwise, RD is assembled per BIG_ENDIAN from bytes A..A+3.
  - Unaligned in-range reads return the assembled bytes. They are flagged by align_err only.
- range_err and align_err are valid in every state.
- Address arithmetic: the compare is done on A as 32-bit unsigned. A + 3 is computed at 33 bits, so A = 32'hFFFFFFFD..F does not wrap to "in range".
- The array is not affected by reset. Power-up contents are undefined until the first load.

## Timing
- Reset values: state = IDLE, busy = 0, ld_ready = 0, ld_done = 0, counters = 0.
- Reset asserted mid-CLEAR or mid-LOAD: the next cycle is IDLE. Partial contents remain. No ld_done is produced.
- ld_start seen at edge k → busy = 1 from cycle k+1. CLEAR occupies cycles k+1 … k+DEPTH_BYTES/4. ld_ready first goes high in cycle k+DEPTH_BYTES/4+1.
- A write at edge t is visible on RD in the next cycle.
- DONE is the cycle after the last accepted byte. busy = 0 and ld_done = 1 in DONE. RD already reflects the new image.
- Minimum load duration: 1 + DEPTH_BYTES/4 + len + 1 cycles, when ld_valid is held high.
- Gaps in ld_valid stall LOAD indefinitely. There is no timeout.

## Structure
- Package instr_mem_pkg:
  - state enum
  - NOP_WORD constant
  - helper function for endian byte assembly
- Sub-module instr_load_ctrl holds the FSM, the counters, and the write-enable/address/data outputs.
- The top level holds the byte array, the write port, the fetch mux, and the error flags.

## Test plan
- Reset, then load 8 bytes E4 11 10 04 E4 13 20 08, with BIG_ENDIAN = 0.
  - ld_ready rises exactly 65 cycles after ld_start (DEPTH 256).
  - ld_done pulses once.
  - RD@A=0 = 32'h041011E4 and RD@A=4 = 32'h082013E4.
  - RD@A=8 = 32'h0 because CLEAR zeroed it.
- Same image with BIG_ENDIAN = 1: RD@A=0 = 32'hE4111004.
- Fetch during CLEAR and during LOAD returns 32'hE1A00000 with busy = 1.
- Pulse ld_start again mid-LOAD: it is ignored and the byte count is unaffected.
- Error flags:
  - A=2 gives align_err = 1 and range_err = 0.
  - A=253 gives range_err = 1 and RD = NOP.
  - A=32'hFFFFFFFE gives range_err = 1.
- Edge cases:
  - ld_len = 0 → DONE follows CLEAR directly, and the array is all zero.
  - ld_len = 300 is clamped to 256.
  - Reset asserted after 3 bytes → IDLE next cycle, no ld_done, and bytes 0..2 are retained.
